// File: rtl/sha_core_512_axi_pkg.sv
// Shared types and address map for the SHA-512 core AXI4 slave.
// Holds FSM state enums, register-map constants, response codes and decode helpers.
package sha_core_512_axi_pkg;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    typedef enum logic [2:0] {
        REG_MSG,
        REG_CTRL,
        REG_STATUS,
        REG_DIGEST,
        REG_NONE
    } region_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_WORD   = 3'd2;

    localparam int MSG_WORDS    = 32;
    localparam int DIGEST_WORDS = 16;

    localparam logic [31:0] ADDR_MSG_LAST     = 32'h0000_007C;
    localparam logic [31:0] ADDR_CTRL         = 32'h0000_0080;
    localparam logic [31:0] ADDR_STATUS       = 32'h0000_0084;
    localparam logic [31:0] ADDR_DIGEST_FIRST = 32'h0000_0100;
    localparam logic [31:0] ADDR_DIGEST_LAST  = 32'h0000_013C;

    // Sub-word address bits are ignored; every access targets the containing word.
    function automatic region_e decode_region(input logic [31:0] addr);
        logic [31:0] word_addr;
        word_addr = {addr[31:2], 2'b00};
        if (word_addr <= ADDR_MSG_LAST) begin
            return REG_MSG;
        end else if (word_addr == ADDR_CTRL) begin
            return REG_CTRL;
        end else if (word_addr == ADDR_STATUS) begin
            return REG_STATUS;
        end else if (word_addr >= ADDR_DIGEST_FIRST && word_addr <= ADDR_DIGEST_LAST) begin
            return REG_DIGEST;
        end
        return REG_NONE;
    endfunction

    function automatic logic burst_unsupported(input logic [1:0] burst, input logic [2:0] size);
        return !(burst == BURST_FIXED || burst == BURST_INCR) || (size != SIZE_WORD);
    endfunction

endpackage

// File: rtl/sha_core_512_msg_regs.sv
// 32 x 32-bit byte-enabled message register file feeding the hash core.
// One write port; all words are exposed in parallel on msg_block.
module sha_core_512_msg_regs
    import sha_core_512_axi_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [4:0]    waddr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    wstrb,
    output logic [1023:0] msg_block
);

    logic [31:0] mem_q [MSG_WORDS];
    logic [31:0] mem_d [MSG_WORDS];

    // NOTE: combinational next-state logic uses blocking '=' and the flops below use '<='.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem_d[waddr][8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end
    end

    // NOTE: built from resettable flops rather than a RAM, since every word must read 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < MSG_WORDS; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    for (genvar k = 0; k < MSG_WORDS; k++) begin : g_flat
        assign msg_block[32*k +: 32] = mem_q[k];
    end

endmodule

// File: rtl/sha_core_512_axi_slave.sv
// AXI4 (burst) slave front-end for a SHA-512 core: message buffer, CTRL/STATUS and digest readback.
// Independent write (W_IDLE/W_DATA/W_RESP) and read (R_IDLE/R_DATA) state machines.
module sha_core_512_axi_slave
    import sha_core_512_axi_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 9,
    parameter int C_S_AXI_ID_WIDTH   = 1
) (
    input  logic                          s00_axi_aclk,
    input  logic                          s00_axi_areset,
    input  logic [C_S_AXI_ID_WIDTH-1:0]   s00_axi_awid,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s00_axi_awaddr,
    input  logic [7:0]                    s00_axi_awlen,
    input  logic [2:0]                    s00_axi_awsize,
    input  logic [1:0]                    s00_axi_awburst,
    input  logic                          s00_axi_awvalid,
    output logic                          s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] s00_axi_wdata,
    input  logic [3:0]                    s00_axi_wstrb,
    input  logic                          s00_axi_wlast,
    input  logic                          s00_axi_wvalid,
    output logic                          s00_axi_wready,
    output logic [C_S_AXI_ID_WIDTH-1:0]   s00_axi_bid,
    output logic [1:0]                    s00_axi_bresp,
    output logic                          s00_axi_bvalid,
    input  logic                          s00_axi_bready,
    input  logic [C_S_AXI_ID_WIDTH-1:0]   s00_axi_arid,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s00_axi_araddr,
    input  logic [7:0]                    s00_axi_arlen,
    input  logic [2:0]                    s00_axi_arsize,
    input  logic [1:0]                    s00_axi_arburst,
    input  logic                          s00_axi_arvalid,
    output logic                          s00_axi_arready,
    output logic [C_S_AXI_ID_WIDTH-1:0]   s00_axi_rid,
    output logic [C_S_AXI_DATA_WIDTH-1:0] s00_axi_rdata,
    output logic [1:0]                    s00_axi_rresp,
    output logic                          s00_axi_rlast,
    output logic                          s00_axi_rvalid,
    input  logic                          s00_axi_rready,
    output logic [1023:0]                 msg_block,
    output logic                          start,
    input  logic                          busy,
    input  logic [511:0]                  digest,
    input  logic                          digest_valid
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int IW = C_S_AXI_ID_WIDTH;
    localparam logic [AW-1:0] ADDR_STEP = AW'(4);

    // Write-side state
    w_state_e       w_state_q, w_state_d;
    logic [AW-1:0]  waddr_q, waddr_d;
    logic [7:0]     awlen_q, awlen_d;
    logic [1:0]     wburst_q, wburst_d;
    logic           w_bad_q, w_bad_d;
    logic           w_err_q, w_err_d;
    logic [8:0]     wcnt_q, wcnt_d;
    logic [IW-1:0]  bid_q, bid_d;
    logic [1:0]     bresp_q, bresp_d;
    logic           awready_q, awready_d;
    logic           wready_q, wready_d;
    logic           bvalid_q, bvalid_d;
    logic           start_q, start_d;
    logic           done_q, done_d;

    logic           aw_hs, w_hs, b_hs;
    logic           beat_err, done_clr;
    logic           msg_we;
    logic [4:0]     msg_waddr;
    logic [31:0]    w_addr32;
    region_e        w_region;

    // Read-side state
    r_state_e       r_state_q, r_state_d;
    logic [AW-1:0]  raddr_q, raddr_d;
    logic [7:0]     arlen_q, arlen_d;
    logic [1:0]     rburst_q, rburst_d;
    logic           r_bad_q, r_bad_d;
    logic [7:0]     rcnt_q, rcnt_d;
    logic [IW-1:0]  rid_q, rid_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [1:0]     rresp_q, rresp_d;
    logic           rlast_q, rlast_d;
    logic           rvalid_q, rvalid_d;
    logic           arready_q, arready_d;

    logic           ar_hs, r_hs;
    logic [AW-1:0]  r_next_addr, ld_addr;
    logic           ld_bad;
    logic [31:0]    ld_addr32, ld_data;
    logic [1:0]     ld_resp;
    region_e        ld_region;

    assign aw_hs = awready_q & s00_axi_awvalid;
    assign w_hs  = wready_q  & s00_axi_wvalid;
    assign b_hs  = bvalid_q  & s00_axi_bready;
    assign ar_hs = arready_q & s00_axi_arvalid;
    assign r_hs  = rvalid_q  & s00_axi_rready;

    sha_core_512_msg_regs u_msg_regs (
        .clk       (s00_axi_aclk),
        .rst       (s00_axi_areset),
        .we        (msg_we),
        .waddr     (msg_waddr),
        .wdata     (s00_axi_wdata),
        .wstrb     (s00_axi_wstrb),
        .msg_block (msg_block)
    );

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_d = w_state_q;
        waddr_d   = waddr_q;
        awlen_d   = awlen_q;
        wburst_d  = wburst_q;
        w_bad_d   = w_bad_q;
        w_err_d   = w_err_q;
        wcnt_d    = wcnt_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        start_d   = 1'b0;
        done_clr  = 1'b0;
        beat_err  = 1'b0;
        msg_we    = 1'b0;
        w_addr32  = 32'(waddr_q);
        w_region  = decode_region(w_addr32);
        msg_waddr = w_addr32[6:2];

        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    w_state_d = W_DATA;
                    waddr_d   = s00_axi_awaddr;
                    awlen_d   = s00_axi_awlen;
                    wburst_d  = s00_axi_awburst;
                    w_bad_d   = burst_unsupported(s00_axi_awburst, s00_axi_awsize);
                    w_err_d   = burst_unsupported(s00_axi_awburst, s00_axi_awsize);
                    wcnt_d    = '0;
                    bid_d     = s00_axi_awid;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    if (!w_bad_q) begin
                        case (w_region)
                            REG_MSG:    msg_we = 1'b1;
                            REG_CTRL:   start_d = s00_axi_wstrb[0] & s00_axi_wdata[0] & ~busy;
                            REG_STATUS: done_clr = s00_axi_wstrb[0] & s00_axi_wdata[1];
                            REG_NONE:   beat_err = 1'b1;
                            default:    ;
                        endcase
                    end
                    w_err_d = w_err_q | beat_err;
                    waddr_d = (wburst_q == BURST_FIXED) ? waddr_q : waddr_q + ADDR_STEP;
                    wcnt_d  = (wcnt_q == 9'h1FF) ? wcnt_q : wcnt_q + 9'd1;
                    if (s00_axi_wlast) begin
                        w_state_d = W_RESP;
                        bresp_d   = (w_err_d || wcnt_q != {1'b0, awlen_q}) ? SLVERR : OKAY;
                    end
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase

        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
        // A completion in the same cycle as a W1C clear keeps done set.
        done_d    = digest_valid ? 1'b1 : (done_clr ? 1'b0 : done_q);
    end

    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            w_state_q <= W_IDLE;
            waddr_q   <= '0;
            awlen_q   <= '0;
            wburst_q  <= '0;
            w_bad_q   <= 1'b0;
            w_err_q   <= 1'b0;
            wcnt_q    <= '0;
            bid_q     <= '0;
            bresp_q   <= OKAY;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            waddr_q   <= waddr_d;
            awlen_q   <= awlen_d;
            wburst_q  <= wburst_d;
            w_bad_q   <= w_bad_d;
            w_err_q   <= w_err_d;
            wcnt_q    <= wcnt_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            start_q   <= start_d;
            done_q    <= done_d;
        end
    end

    // The beat being loaded comes from AR in R_IDLE, otherwise from the advancing burst address.
    always_comb begin
        r_next_addr = (rburst_q == BURST_FIXED) ? raddr_q : raddr_q + ADDR_STEP;
        ld_addr     = (r_state_q == R_IDLE) ? s00_axi_araddr : r_next_addr;
        ld_bad      = (r_state_q == R_IDLE) ? burst_unsupported(s00_axi_arburst, s00_axi_arsize)
                                            : r_bad_q;
        ld_addr32   = 32'(ld_addr);
        ld_region   = decode_region(ld_addr32);
        ld_data     = '0;
        ld_resp     = OKAY;
        if (ld_bad || ld_region == REG_NONE) begin
            ld_resp = SLVERR;
        end else begin
            case (ld_region)
                REG_MSG:    ld_data = msg_block[{ld_addr32[6:2], 5'd0} +: 32];
                REG_STATUS: ld_data = {30'd0, done_q, busy};
                REG_DIGEST: ld_data = digest[{ld_addr32[5:2], 5'd0} +: 32];
                default:    ld_data = '0;
            endcase
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        arlen_d   = arlen_q;
        rburst_d  = rburst_q;
        r_bad_d   = r_bad_q;
        rcnt_d    = rcnt_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;

        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_d = R_DATA;
                    raddr_d   = s00_axi_araddr;
                    arlen_d   = s00_axi_arlen;
                    rburst_d  = s00_axi_arburst;
                    r_bad_d   = ld_bad;
                    rcnt_d    = '0;
                    rid_d     = s00_axi_arid;
                    rdata_d   = ld_data;
                    rresp_d   = ld_resp;
                    rlast_d   = (s00_axi_arlen == 8'd0);
                end
            end
            R_DATA: begin
                if (r_hs) begin
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                        rlast_d   = 1'b0;
                    end else begin
                        raddr_d = r_next_addr;
                        rcnt_d  = rcnt_q + 8'd1;
                        rdata_d = ld_data;
                        rresp_d = ld_resp;
                        rlast_d = (rcnt_q + 8'd1 == arlen_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase

        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
    end

    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            r_state_q <= R_IDLE;
            raddr_q   <= '0;
            arlen_q   <= '0;
            rburst_q  <= '0;
            r_bad_q   <= 1'b0;
            rcnt_q    <= '0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
            rlast_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            raddr_q   <= raddr_d;
            arlen_q   <= arlen_d;
            rburst_q  <= rburst_d;
            r_bad_q   <= r_bad_d;
            rcnt_q    <= rcnt_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            rvalid_q  <= rvalid_d;
            arready_q <= arready_d;
        end
    end

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = wready_q;
    assign s00_axi_bid     = bid_q;
    assign s00_axi_bresp   = bresp_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rid     = rid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = rresp_q;
    assign s00_axi_rlast   = rlast_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign start           = start_q;

endmodule

// File: tb/tb_sha_core_512_axi_slave.sv
// Self-checking bench for sha_core_512_axi_slave: directed cases plus random bursts
// compared against an address-map level model of the register space.
module tb_sha_core_512_axi_slave;

    logic         clk = 1'b0;
    logic         rst;
    logic [0:0]   awid, bid, arid, rid;
    logic [8:0]   awaddr, araddr;
    logic [7:0]   awlen, arlen;
    logic [2:0]   awsize, arsize;
    logic [1:0]   awburst, arburst, bresp, rresp;
    logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rlast, rvalid, rready;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb;
    logic [1023:0] msg_block;
    logic         start, busy, digest_valid;
    logic [511:0] digest;

    always #5 clk = ~clk;

    sha_core_512_axi_slave dut (
        .s00_axi_aclk    (clk),
        .s00_axi_areset  (rst),
        .s00_axi_awid    (awid),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awlen   (awlen),
        .s00_axi_awsize  (awsize),
        .s00_axi_awburst (awburst),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wlast   (wlast),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bid     (bid),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_arid    (arid),
        .s00_axi_araddr  (araddr),
        .s00_axi_arlen   (arlen),
        .s00_axi_arsize  (arsize),
        .s00_axi_arburst (arburst),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rid     (rid),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rlast   (rlast),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .msg_block       (msg_block),
        .start           (start),
        .busy            (busy),
        .digest          (digest),
        .digest_valid    (digest_valid)
    );

    int total = 0;
    int bad   = 0;
    int start_cycles = 0;
    logic last_start;

    // Reference model of the register space
    logic [31:0] msg_m [32];
    logic [31:0] dig_m [16];
    logic        done_m;

    // Beat buffers shared between the stimulus tasks and the checks
    logic [31:0] wbuf_d [16];
    logic [3:0]  wbuf_s [16];
    logic [31:0] rbuf_d [16];
    logic [1:0]  rbuf_r [16];
    logic        rbuf_l [16];

    always @(negedge clk) if (start === 1'b1) start_cycles++;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // 0 message, 1 ctrl, 2 status, 3 digest, 4 unmapped
    function automatic int kind(input logic [8:0] a);
        int w;
        w = int'(a) & 'h1FC;
        if (w < 'h80) return 0;
        if (w == 'h80) return 1;
        if (w == 'h84) return 2;
        if (w >= 'h100 && w < 'h140) return 3;
        return 4;
    endfunction

    function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size);
        return (burst > 2'd1) || (size != 3'd2);
    endfunction

    function automatic logic [8:0] next_addr(input logic [8:0] a, input logic [1:0] burst);
        return (burst == 2'd0) ? a : a + 9'd4;
    endfunction

    function automatic logic [33:0] model_read(input logic [8:0] a, input logic badb);
        if (badb) return {2'b10, 32'd0};
        case (kind(a))
            0: return {2'b00, msg_m[a[6:2]]};
            1: return {2'b00, 32'd0};
            2: return {2'b00, 30'd0, done_m, busy};
            3: return {2'b00, dig_m[(int'(a) - 'h100) / 4]};
            default: return {2'b10, 32'd0};
        endcase
    endfunction

    task automatic model_write(input logic [8:0] addr, input int len, input logic [1:0] burst,
                               input logic [2:0] size, input int nbeats, output logic [1:0] resp);
        logic err, badb;
        logic [8:0] a;
        badb = burst_bad(burst, size);
        err  = badb || (nbeats != len + 1);
        a    = addr;
        for (int i = 0; i < nbeats; i++) begin
            if (!badb) begin
                case (kind(a))
                    0: for (int b = 0; b < 4; b++)
                           if (wbuf_s[i][b]) msg_m[a[6:2]][8*b +: 8] = wbuf_d[i][8*b +: 8];
                    2: if (wbuf_s[i][0] && wbuf_d[i][1]) done_m = 1'b0;
                    4: err = 1'b1;
                    default: ;
                endcase
            end
            a = next_addr(a, burst);
        end
        resp = err ? 2'b10 : 2'b00;
    endtask

    task automatic axi_write(input logic [8:0] addr, input int len, input logic [1:0] burst,
                             input logic [2:0] size, input int nbeats, input logic id,
                             output logic [1:0] resp, output logic id_o);
        int n;
        awid = id; awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("aw_timeout", 1, 0);
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            wdata = wbuf_d[i]; wstrb = wbuf_s[i]; wlast = (i == nbeats - 1); wvalid = 1'b1;
            n = 0;
            while (!wready && n < 200) begin @(negedge clk); n++; end
            if (n >= 200) check("w_timeout", 1, 0);
            @(negedge clk);
            last_start = start;
            wvalid = 1'b0; wlast = 1'b0;
            if ($urandom % 4 == 0) @(negedge clk);
        end
        if ($urandom % 2 == 0) repeat (2) @(negedge clk);
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("b_timeout", 1, 0);
        resp = bresp; id_o = bid;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [8:0] addr, input int len, input logic [1:0] burst,
                            input logic [2:0] size, input logic id, output logic id_o);
        int n, i;
        logic held;
        logic [31:0] hd;
        logic [1:0]  hr;
        logic        hl;
        arid = id; araddr = addr; arlen = 8'(len); arsize = size; arburst = burst; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("ar_timeout", 1, 0);
        @(negedge clk);
        arvalid = 1'b0;
        check("rvalid_latency", rvalid, 1);
        i = 0; n = 0; held = 1'b0; id_o = 1'b0;
        hd = '0; hr = '0; hl = 1'b0;
        while (i <= len && n < 500) begin
            rready = ($urandom % 4 != 0);
            if (held) begin
                check("rhold", {rdata, rresp, rlast}, {hd, hr, hl});
                held = 1'b0;
            end
            if (rvalid && rready) begin
                rbuf_d[i] = rdata; rbuf_r[i] = rresp; rbuf_l[i] = rlast; id_o = rid;
                i++;
            end else if (rvalid) begin
                held = 1'b1; hd = rdata; hr = rresp; hl = rlast;
            end
            @(negedge clk);
            n++;
        end
        rready = 1'b0;
        if (n >= 500) check("r_timeout", 1, 0);
        check("rvalid_drop", rvalid, 0);
    endtask

    task automatic write_and_check(input string tag, input logic [8:0] addr, input int len,
                                   input logic [1:0] burst, input logic [2:0] size,
                                   input int nbeats, input logic id);
        logic [1:0] exp_resp, got_resp;
        logic       got_id;
        model_write(addr, len, burst, size, nbeats, exp_resp);
        axi_write(addr, len, burst, size, nbeats, id, got_resp, got_id);
        check({tag, ".bresp"}, got_resp, exp_resp);
        check({tag, ".bid"}, got_id, id);
    endtask

    task automatic read_and_check(input string tag, input logic [8:0] addr, input int len,
                                  input logic [1:0] burst, input logic [2:0] size, input logic id);
        logic        got_id, badb;
        logic [8:0]  a;
        logic [33:0] e;
        axi_read(addr, len, burst, size, id, got_id);
        badb = burst_bad(burst, size);
        a = addr;
        for (int i = 0; i <= len; i++) begin
            e = model_read(a, badb);
            check($sformatf("%s.data%0d", tag, i), rbuf_d[i], e[31:0]);
            check($sformatf("%s.resp%0d", tag, i), rbuf_r[i], e[33:32]);
            check($sformatf("%s.last%0d", tag, i), rbuf_l[i], (i == len));
            a = next_addr(a, burst);
        end
        check({tag, ".rid"}, got_id, id);
    endtask

    task automatic drive_idle();
        awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'd1; arvalid = 1'b0;
        rready = 1'b0; digest_valid = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".awready"}, awready, 0);
        check({tag, ".arready"}, arready, 0);
        check({tag, ".wready"}, wready, 0);
        check({tag, ".bvalid"}, bvalid, 0);
        check({tag, ".rvalid"}, rvalid, 0);
        check({tag, ".rlast"}, rlast, 0);
        check({tag, ".start"}, start, 0);
        for (int k = 0; k < 32; k++) check($sformatf("%s.msg%0d", tag, k), msg_block[32*k +: 32], 0);
    endtask

    function automatic logic [8:0] rand_addr();
        case ($urandom % 8)
            0, 1, 2, 3: return 9'(($urandom % 32) * 4);
            4:          return 9'h084;
            5:          return 9'(32'h100 + ($urandom % 16) * 4);
            6:          return 9'(32'h1F0 + ($urandom % 4) * 4);
            default:    return 9'(32'h140 + ($urandom % 8) * 4);
        endcase
    endfunction

    initial begin
        int s, len, nbeats;
        logic [1:0] burst;
        logic [2:0] size;

        drive_idle();
        busy = 1'b0;
        digest = '0;
        for (int k = 0; k < 16; k++) dig_m[k] = '0;
        for (int k = 0; k < 32; k++) msg_m[k] = '0;
        done_m = 1'b0;
        last_start = 1'b0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check("reset.bresp", bresp, 0);
        check("reset.rresp", rresp, 0);
        check("reset.bid", bid, 0);
        check("reset.rid", rid, 0);
        check("reset.rdata", rdata, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset.awready", awready, 1);
        check("post_reset.arready", arready, 1);

        // INCR burst of 1..8 and readback
        for (int i = 0; i < 8; i++) begin wbuf_d[i] = 32'(i + 1); wbuf_s[i] = 4'hF; end
        write_and_check("incr8_wr", 9'h000, 7, 2'd1, 3'd2, 8, 1'b1);
        read_and_check("incr8_rd", 9'h000, 7, 2'd1, 3'd2, 1'b1);
        for (int i = 0; i < 8; i++) check($sformatf("incr8.lit%0d", i), rbuf_d[i], 32'(i + 1));

        // Partial byte strobes
        wbuf_d[0] = 32'h1122_3344; wbuf_s[0] = 4'hF;
        write_and_check("strb_a", 9'h004, 0, 2'd1, 3'd2, 1, 1'b0);
        wbuf_d[0] = 32'hAABB_CCDD; wbuf_s[0] = 4'h3;
        write_and_check("strb_b", 9'h004, 0, 2'd1, 3'd2, 1, 1'b0);
        read_and_check("strb_rd", 9'h004, 0, 2'd1, 3'd2, 1'b0);
        check("strb.lit", rbuf_d[0], 32'h1122_CCDD);

        // CTRL start with busy low then high
        wbuf_d[0] = 32'h1; wbuf_s[0] = 4'hF;
        s = start_cycles;
        write_and_check("ctrl_idle", 9'h080, 0, 2'd1, 3'd2, 1, 1'b0);
        repeat (3) @(negedge clk);
        check("ctrl_idle.pulses", start_cycles - s, 1);
        check("ctrl_idle.timing", last_start, 1);
        busy = 1'b1;
        s = start_cycles;
        write_and_check("ctrl_busy", 9'h080, 0, 2'd1, 3'd2, 1, 1'b1);
        repeat (3) @(negedge clk);
        check("ctrl_busy.pulses", start_cycles - s, 0);
        busy = 1'b0;

        // Digest completion, STATUS.done and W1C clear
        for (int k = 0; k < 16; k++) dig_m[k] = $urandom;
        dig_m[0] = 32'hDEAD_BEEF;
        for (int k = 0; k < 16; k++) digest[32*k +: 32] = dig_m[k];
        digest_valid = 1'b1;
        @(negedge clk);
        digest_valid = 1'b0;
        done_m = 1'b1;
        read_and_check("status_set", 9'h084, 0, 2'd1, 3'd2, 1'b0);
        check("status_set.lit", rbuf_d[0], 32'h2);
        read_and_check("digest_rd", 9'h100, 15, 2'd1, 3'd2, 1'b1);
        check("digest.lit", rbuf_d[0], 32'hDEAD_BEEF);
        wbuf_d[0] = 32'h2; wbuf_s[0] = 4'hF;
        write_and_check("status_clr", 9'h084, 0, 2'd1, 3'd2, 1, 1'b0);
        read_and_check("status_clr_rd", 9'h084, 0, 2'd1, 3'd2, 1'b0);
        check("status_clr.lit", rbuf_d[0], 32'h0);

        // Error responses
        read_and_check("unmapped_rd", 9'h140, 1, 2'd1, 3'd2, 1'b0);
        check("unmapped.resp0", rbuf_r[0], 2'b10);
        check("unmapped.resp1", rbuf_r[1], 2'b10);
        wbuf_d[0] = 32'hCAFE_F00D; wbuf_s[0] = 4'hF;
        write_and_check("wrap_wr", 9'h000, 0, 2'd2, 3'd2, 1, 1'b1);
        read_and_check("wrap_rd", 9'h000, 0, 2'd1, 3'd2, 1'b0);
        check("wrap.word0", rbuf_d[0], 32'h1);
        write_and_check("size1_wr", 9'h008, 0, 2'd1, 3'd1, 1, 1'b0);
        wbuf_d[1] = 32'h5555_AAAA; wbuf_s[1] = 4'hF;
        write_and_check("short_burst", 9'h010, 3, 2'd1, 3'd2, 2, 1'b0);
        read_and_check("err_rd", 9'h000, 7, 2'd1, 3'd2, 1'b1);

        // Reset in the middle of beat 3 of an 8-beat write
        awaddr = 9'h000; awlen = 8'd7; awburst = 2'd1; awsize = 3'd2; awid = 1'b0; awvalid = 1'b1;
        s = 0;
        while (!awready && s < 200) begin @(negedge clk); s++; end
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wdata = $urandom; wstrb = 4'hF; wvalid = 1'b1;
            s = 0;
            while (!wready && s < 200) begin @(negedge clk); s++; end
            @(negedge clk);
        end
        wdata = $urandom; wvalid = 1'b1;
        rst = 1'b1;
        #1;
        check_idle_outputs("mid_reset");
        drive_idle();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 32; k++) msg_m[k] = '0;
        done_m = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin wbuf_d[i] = $urandom; wbuf_s[i] = 4'hF; end
        write_and_check("post_rst_wr", 9'h020, 7, 2'd1, 3'd2, 8, 1'b1);
        read_and_check("post_rst_rd", 9'h020, 7, 2'd1, 3'd2, 1'b1);

        // Random bursts against the model
        for (int it = 0; it < 60; it++) begin
            len = $urandom % 8;
            case ($urandom % 10)
                0:       burst = 2'd0;
                1:       burst = 2'(2 + $urandom % 2);
                default: burst = 2'd1;
            endcase
            size = ($urandom % 10 == 0) ? 3'($urandom % 8) : 3'd2;
            nbeats = (len > 0 && $urandom % 8 == 0) ? 1 + ($urandom % len) : len + 1;
            for (int i = 0; i < 16; i++) begin
                wbuf_d[i] = $urandom;
                wbuf_s[i] = 4'($urandom);
            end
            write_and_check($sformatf("rnd%0d_wr", it), rand_addr(), len, burst, size, nbeats,
                            1'($urandom));
            len = $urandom % 8;
            burst = ($urandom % 8 == 0) ? 2'd0 : 2'd1;
            size = ($urandom % 12 == 0) ? 3'd1 : 3'd2;
            read_and_check($sformatf("rnd%0d_rd", it), rand_addr(), len, burst, size, 1'($urandom));
        end

        for (int k = 0; k < 32; k++) check($sformatf("final.msg%0d", k), msg_block[32*k +: 32], msg_m[k]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sha_core_512_axi_slave.md
SHA_CORE_512_AXI_SLAVE -- requirements
Module: sha_core_512_axi_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 9, byte address width.
REQ-003 SHALL have parameter C_S_AXI_ID_WIDTH, default 1, AXI ID width.
REQ-004 s00_axi_aclk  in  1  sole clock; all logic on rising edge.
REQ-005 s00_axi_areset  in  1  reset, asynchronous, active-high.
REQ-006 s00_axi_awid/awaddr/awlen/awsize/awburst  in  ID/ADDR/8/3/2  write address channel.
REQ-007 s00_axi_awvalid in 1, s00_axi_awready out 1  AW handshake.
REQ-008 s00_axi_wdata/wstrb/wlast/wvalid  in  32/4/1/1; s00_axi_wready out 1  write data channel.
REQ-009 s00_axi_bid/bresp/bvalid  out  ID/2/1; s00_axi_bready in 1  write response channel.
REQ-010 s00_axi_arid/araddr/arlen/arsize/arburst/arvalid  in  ID/ADDR/8/3/2/1; s00_axi_arready out 1.
REQ-011 s00_axi_rid/rdata/rresp/rlast/rvalid  out  ID/32/2/1/1; s00_axi_rready in 1.
REQ-012 msg_block  out  1024  message words; word k at [32k+:32].
REQ-013 start  out  1  one-cycle pulse to hash core.
REQ-014 busy  in  1  hash core busy; digest  in  512; digest_valid  in  1  one-cycle completion pulse.

Function
REQ-015 Address map SHALL be: 0x000-0x07C message (32 words RW); 0x080 CTRL (bit0 start, reads 0); 0x084 STATUS (bit0 busy, RO; bit1 done, W1C); 0x100-0x13C digest word k=(addr-0x100)/4 (RO); all else unmapped.
REQ-016 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; awready=1 only in W_IDLE; AW accept latches id, addr, len, burst, size and goes to W_DATA.
REQ-017 In W_DATA wready SHALL be 1; each accepted beat writes enabled bytes per wstrb; updated value is visible to reads from the next cycle.
REQ-018 Beat address SHALL increment by 4 for INCR, stay constant for FIXED, and wrap modulo 2^C_S_AXI_ADDR_WIDTH.
REQ-019 The write burst SHALL end on beat with wlast=1 -> W_RESP; bvalid held with bid=latched id until bready, then W_IDLE.
REQ-020 bresp SHALL be SLVERR (2'b10) if any beat hits unmapped space, burst is WRAP/reserved, size != 2, or beat count != awlen+1; otherwise OKAY; WRAP/reserved/size!=2 bursts SHALL write nothing.
REQ-021 Writes to RO locations SHALL be ignored with OKAY; unmapped-beat writes SHALL be dropped.
REQ-022 A CTRL beat with wstrb[0]=1 and wdata[0]=1 SHALL pulse start exactly one cycle, the cycle after the beat, only if busy=0; otherwise no pulse, response OKAY.
REQ-023 STATUS.done SHALL set on digest_valid, clear on a STATUS write with bit1=1; simultaneous set and clear: set wins.
REQ-024 Read FSM SHALL have states R_IDLE, R_DATA; arready=1 only in R_IDLE; rvalid first asserts the cycle after AR accept.
REQ-025 Each beat SHALL hold rdata/rresp/rlast stable while rvalid=1 and rready=0; advance on rvalid&rready; rlast=1 on beat arlen; R_IDLE after last.
REQ-026 Unmapped beats, WRAP/reserved bursts, or size!=2 SHALL return rdata=0, rresp=SLVERR per beat; full arlen+1 beats always returned.
REQ-027 Read and write FSMs SHALL be independent; same-cycle write and read of one word returns the old value.

Reset
REQ-028 While s00_axi_areset=1: FSMs idle, awready/arready/wready/bvalid/rvalid/rlast/start=0, bresp/rresp/bid/rid/rdata=0, message words and done=0.
REQ-029 awready and arready SHALL first assert the cycle after reset deasserts; reset mid-burst SHALL abandon the transaction without response.

Structure
REQ-030 Package sha_core_512_axi_pkg SHALL hold FSM state enums, address-map constants, and resp codes OKAY/SLVERR.
REQ-031 Sub-module sha_core_512_msg_regs SHALL hold the 32x32 byte-enabled message register file.

Verification
REQ-032 INCR awlen=7 write 1..8 at 0x000, then 8-beat read -> rdata 1..8, OKAY, rlast on beat 8 only, bresp OKAY.
REQ-033 Word 0x004=0x11223344, write 0xAABBCCDD wstrb=0x3 -> readback 0x1122CCDD.
REQ-034 CTRL write 0x1, busy=0 -> start single pulse; repeat with busy=1 -> no pulse, bresp OKAY.
REQ-035 digest_valid with digest[31:0]=0xDEADBEEF -> STATUS=0x2, read 0x100=0xDEADBEEF; write STATUS 0x2 -> STATUS=0x0.
REQ-036 2-beat read at 0x140 -> rdata 0, rresp SLVERR both beats; WRAP write at 0x000 -> SLVERR, word 0 unchanged.
REQ-037 Reset during beat 3 of 8-beat write -> all valids 0, message cleared; following 8-beat write/read passes.
